// File: rtl/debounce_pkg.sv
// debounce_pkg: shared definitions for the keypad debouncer.
//   rep_phase_e            - auto-repeat phase (initial delay, then steady rate)
//   clog2()                - ceiling log2, usable in constant expressions
//   DEBOUNCE_CNT_W_CHECK   - elaboration-time guard that a counter width can
//                            hold the largest compare value it will meet
`ifndef DEBOUNCE_PKG_SV
`define DEBOUNCE_PKG_SV

package debounce_pkg;

    typedef enum logic {
        REP_DELAY = 1'b0,
        REP_RATE  = 1'b1
    } rep_phase_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// Fails elaboration when cnt_w bits cannot represent max_val.
`define DEBOUNCE_CNT_W_CHECK(cnt_w, max_val) \
    if (debounce_pkg::clog2((max_val) + 1) > (cnt_w)) begin : g_cnt_w_check \
        $fatal(1, "debounce: CNT_W too narrow for the largest counter compare value"); \
    end

`endif

// File: rtl/debounce_chan.sv
// debounce_chan: one push-button channel.
//   clk, rst_n  - system clock, synchronous active-low reset
//   tick        - shared timebase strobe, one clk cycle per prescaler period
//   pin         - raw asynchronous button pin
//   level       - debounced level, 1 = pressed
//   down / up   - one-cycle strobes coincident with level rising / falling
//   rpt         - one-cycle auto-repeat strobe while held (0 if REPEAT_EN = 0)
//   evt_next    - OR of the strobes about to be registered, for the top-level
//                 any_event register
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int ACTIVE_LOW   = 1,
    parameter int STABLE_TICKS = 64,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic down,
    output logic up,
    output logic rpt,
    output logic evt_next
);

    localparam logic             INACTIVE_PIN = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic [CNT_W-1:0]       stab_cnt;
    logic [CNT_W-1:0]       stab_cnt_next;
    logic                   toggle;
    logic                   level_next;
    logic                   down_next;
    logic                   up_next;
    logic                   rpt_next;

    // Synchroniser loads the idle pin level on reset so that releasing reset
    // with the button up produces no event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{INACTIVE_PIN}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign sample = sync_q[SYNC_STAGES-1] ^ INACTIVE_PIN;

    // Any sample agreeing with the current level restarts qualification.
    always_comb begin
        toggle        = 1'b0;
        stab_cnt_next = stab_cnt;
        if (sample == level) begin
            stab_cnt_next = '0;
        end else if (tick) begin
            if (stab_cnt == STABLE_LAST) begin
                toggle        = 1'b1;
                stab_cnt_next = '0;
            end else begin
                stab_cnt_next = stab_cnt + 1'b1;
            end
        end
        level_next = level ^ toggle;
        down_next  = toggle & ~level;
        up_next    = toggle & level;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stab_cnt <= '0;
            level    <= 1'b0;
            down     <= 1'b0;
            up       <= 1'b0;
        end else begin
            stab_cnt <= stab_cnt_next;
            level    <= level_next;
            down     <= down_next;
            up       <= up_next;
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_repeat
            localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
            localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

            rep_phase_e       phase;
            rep_phase_e       phase_next;
            logic [CNT_W-1:0] rep_cnt;
            logic [CNT_W-1:0] rep_cnt_next;

            // A release on this edge (up_next) clears the repeat state and
            // suppresses any repeat strobe landing on the same tick.
            always_comb begin
                phase_next   = phase;
                rep_cnt_next = rep_cnt;
                rpt_next     = 1'b0;
                if (!level || up_next) begin
                    phase_next   = REP_DELAY;
                    rep_cnt_next = '0;
                end else if (tick) begin
                    if (phase == REP_DELAY) begin
                        if (rep_cnt == DELAY_LAST) begin
                            rpt_next     = 1'b1;
                            rep_cnt_next = '0;
                            phase_next   = REP_RATE;
                        end else begin
                            rep_cnt_next = rep_cnt + 1'b1;
                        end
                    end else begin
                        if (rep_cnt == RATE_LAST) begin
                            rpt_next     = 1'b1;
                            rep_cnt_next = '0;
                        end else begin
                            rep_cnt_next = rep_cnt + 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    phase   <= REP_DELAY;
                    rep_cnt <= '0;
                    rpt     <= 1'b0;
                end else begin
                    phase   <= phase_next;
                    rep_cnt <= rep_cnt_next;
                    rpt     <= rpt_next;
                end
            end
        end else begin : g_no_repeat
            assign rpt_next = 1'b0;
            assign rpt      = 1'b0;
        end
    endgenerate

    assign evt_next = down_next | up_next | rpt_next;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel push-button debouncer with press/release and
// hold-to-repeat strobes, all channels sharing one timebase prescaler.
//   clk, rst_n  - system clock, synchronous active-low reset
//   pb_in       - raw asynchronous button pins
//   pb_state    - debounced levels, 1 = pressed
//   pb_down     - one-cycle strobe per channel on accepted press
//   pb_up       - one-cycle strobe per channel on accepted release
//   pb_repeat   - one-cycle strobe per channel per auto-repeat
//   any_event   - OR of all strobes, registered alongside them
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N            = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int ACTIVE_LOW   = 1,
    parameter int PRESCALE     = 256,
    parameter int STABLE_TICKS = 64,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] pb_in,
    output logic [N-1:0] pb_state,
    output logic [N-1:0] pb_down,
    output logic [N-1:0] pb_up,
    output logic [N-1:0] pb_repeat,
    output logic         any_event
);

    localparam int MAX_DR  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int MAX_CNT = (STABLE_TICKS > MAX_DR) ? STABLE_TICKS : MAX_DR;
    // At least one bit even when PRESCALE = 1 (tick then stays high).
    localparam int PRE_W   = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    `DEBOUNCE_CNT_W_CHECK(CNT_W, MAX_CNT)

    if (SYNC_STAGES < 2 || PRESCALE < 1 || STABLE_TICKS < 1 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $fatal(1, "debounce_multi: parameter below its minimum");
    end

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [N-1:0]     evt_next;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < N; i++) begin : g_chan
            debounce_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .ACTIVE_LOW  (ACTIVE_LOW),
                .STABLE_TICKS(STABLE_TICKS),
                .REPEAT_EN   (REPEAT_EN),
                .REPEAT_DELAY(REPEAT_DELAY),
                .REPEAT_RATE (REPEAT_RATE),
                .CNT_W       (CNT_W)
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .tick    (tick),
                .pin     (pb_in[i]),
                .level   (pb_state[i]),
                .down    (pb_down[i]),
                .up      (pb_up[i]),
                .rpt     (pb_repeat[i]),
                .evt_next(evt_next[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_event <= 1'b0;
        end else begin
            any_event <= |evt_next;
        end
    end

endmodule
